fpdiv_issue: RTL

Request-side sequencer for the `fpdiv` single-precision divider core. It accepts operand pairs on a valid/ready request channel and buffers them in a small FIFO. It issues one division at a time to the core with a start pulse, waits for the core's done pulse, and returns quotients in order on a valid/ready response channel. It is the hardware initiator that replaces bench-driven operand sequencing when the divider is embedded in the datapath.

---
 rtl/fpdiv_pkg.sv | 31 +++
 rtl/fpdiv_issue_fifo.sv | 49 ++++
 rtl/fpdiv_issue.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fpdiv_pkg.sv
// fpdiv_pkg -- shared types and binary32 helpers for the fpdiv issue sequencer.
// Revision: 1.0
`default_nettype none

package fpdiv_pkg;

  localparam int FP32_W     = 32;
  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;

  localparam logic [FP32_W-1:0] FP32_MAG_MASK = {1'b0, {(FP32_W-1){1'b1}}};
  localparam logic [FP32_W-1:0] FP32_INF_MAG  = {1'b0, {FP32_EXP_W{1'b1}}, {FP32_MAN_W{1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  function automatic logic fp32_is_zero(input logic [FP32_W-1:0] x);
    return (x & FP32_MAG_MASK) == '0;
  endfunction

  // Any magnitude above +inf has an all-ones exponent and a non-zero mantissa.
  function automatic logic fp32_is_nan(input logic [FP32_W-1:0] x);
    return (x & FP32_MAG_MASK) > FP32_INF_MAG;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fpdiv_issue_fifo.sv
// fpdiv_issue_fifo -- registered synchronous request FIFO with wrap-bit pointers.
// Revision: 1.0
`default_nettype none

module fpdiv_issue_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 66
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && reset) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/fpdiv_issue.sv
// fpdiv_issue -- request FIFO + one-at-a-time issue sequencer for the fpdiv core.
// Optional: FPDIV_ISSUE_ZERO_BYPASS_EN answers +-0 / finite-or-inf divisions locally. Revision: 1.0
`default_nettype none

module fpdiv_issue
  import fpdiv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_n,
  input  logic [31:0]      req_d,
  input  logic [1:0]       req_rm,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_q,
  output logic             div_start,
  output logic [31:0]      div_n,
  output logic [31:0]      div_d,
  output logic [1:0]       div_rm,
  input  logic             div_done,
  input  logic [31:0]      div_q,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int ENTRY_W = 2*FP32_W + 2;

  state_t               state;
  logic                 ready_en;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [ENTRY_W-1:0]   head;
  logic [FP32_W-1:0]    head_n;
  logic [FP32_W-1:0]    head_d;
  logic [1:0]           head_rm;
  logic                 slot_free;
  logic                 pop_go;
  logic                 bypass_hit;
  logic                 load_core;
  logic                 load_any;
  logic [FP32_W-1:0]    load_val;

  fpdiv_issue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (req_valid && req_ready),
    .push_data ({req_n, req_d, req_rm}),
    .pop       (pop_go),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_n  = head[ENTRY_W-1 -: FP32_W];
  assign head_d  = head[FP32_W+1 -: FP32_W];
  assign head_rm = head[1:0];

  // ready_en keeps req_ready low through reset and for as long as reset is held.
  assign req_ready = ready_en && !fifo_full;
  assign busy      = (state != IDLE) || !fifo_empty;
  assign slot_free = !rsp_valid || rsp_ready;
  assign pop_go    = (state == IDLE) && !fifo_empty && slot_free;

`ifdef FPDIV_ISSUE_ZERO_BYPASS_EN
  assign bypass_hit = fp32_is_zero(head_n) && !fp32_is_zero(head_d) && !fp32_is_nan(head_d);
`else
  assign bypass_hit = 1'b0;
`endif

  assign load_core = (state == WAIT) && div_done;
  assign load_any  = load_core || (pop_go && bypass_hit);
  assign load_val  = load_core ? div_q : {head_n[FP32_W-1] ^ head_d[FP32_W-1], {(FP32_W-1){1'b0}}};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      ready_en  <= 1'b0;
      div_start <= 1'b0;
      div_n     <= '0;
      div_d     <= '0;
      div_rm    <= '0;
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
      done_cnt  <= '0;
    end else begin
      ready_en  <= 1'b1;
      div_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pop_go && !bypass_hit) begin
            div_n     <= head_n;
            div_d     <= head_d;
            div_rm    <= head_rm;
            div_start <= 1'b1;
            state     <= START;
          end
        end
        START:   state <= WAIT;
        WAIT:    if (div_done) state <= IDLE;
        default: state <= IDLE;
      endcase

      // A new result may overwrite a response being accepted this same cycle.
      if (load_any) begin
        rsp_q     <= load_val;
        rsp_valid <= 1'b1;
        done_cnt  <= done_cnt + CNT_W'(1);
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
